// File: rtl/pdu_run_ctrl.sv
// pdu_run_ctrl: debounced step/continue run control for the CPU clock enable,
// with free-run divider, PC breakpoint and I/O-wait stall.
module pdu_run_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int RUN_DIV   = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        step,
    input  logic        cont,
    input  logic [31:0] pc,
    input  logic        bp_we,
    input  logic [31:0] bp_wdata,
    input  logic        bp_en,
    input  logic        io_wait,
    output logic        cpu_en,
    output logic        pause,
    output logic [1:0]  state,
    output logic [31:0] cyc_cnt
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;

    typedef enum logic [1:0] {PAUSE, STEP, RUN, WAIT} state_t;

    state_t        st, st_nx;
    logic [1:0]    raw, s1, s2, acc, acc_d, press;
    logic [CW-1:0] db_cnt [2];
    logic [31:0]   bp;
    logic [DW-1:0] div;
    logic          armed, armed_nx, en_nx, fire, bp_hit, step_p, cont_p;

    assign raw    = {cont, step};
    assign step_p = press[0];
    assign cont_p = press[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1     <= '0;
            s2     <= '0;
            acc    <= '0;
            acc_d  <= '0;
            press  <= '0;
            db_cnt <= '{default: '0};
        end else begin
            s1    <= raw;
            s2    <= s1;
            acc_d <= acc;
            press <= acc & ~acc_d;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == acc[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    acc[i]    <= s2[i];
                    db_cnt[i] <= '0;
                end else
                    db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    assign fire   = div == DW'(RUN_DIV - 1);
    // armed blocks an immediate re-stop when resuming from a breakpoint PC
    assign bp_hit = bp_en && pc == bp && armed;

    always_comb begin
        st_nx    = st;
        en_nx    = 1'b0;
        armed_nx = armed;
        case (st)
            PAUSE: begin
                st_nx    = cont_p ? RUN : step_p ? STEP : PAUSE;
                armed_nx = cont_p ? 1'b0 : armed;
            end
            STEP: begin
                st_nx = PAUSE;
                en_nx = 1'b1;
            end
            RUN: begin
                if (cont_p)
                    st_nx = PAUSE;
                else if (io_wait)
                    st_nx = WAIT;
                else if (fire && bp_hit)
                    st_nx = PAUSE;
                else if (fire) begin
                    en_nx    = 1'b1;
                    armed_nx = 1'b1;
                end
            end
            WAIT:    st_nx = cont_p ? PAUSE : io_wait ? WAIT : RUN;
            default: st_nx = PAUSE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st      <= PAUSE;
            cpu_en  <= 1'b0;
            cyc_cnt <= '0;
            armed   <= 1'b0;
            bp      <= '0;
            div     <= '0;
        end else begin
            st      <= st_nx;
            cpu_en  <= en_nx;
            cyc_cnt <= cyc_cnt + {31'b0, en_nx};
            armed   <= armed_nx;
            if (bp_we)
                bp <= bp_wdata;
            div <= (st != RUN || fire) ? '0 : div + 1'b1;
        end
    end

    assign state = st;
    assign pause = st != RUN;
endmodule
